// File: rtl/shift_reg_input.sv
// Receiver for a three-wire 74HC595-style link (data, shift clock, latch), oversampled on CLK.
// Define SHIFT_REG_INPUT_GLITCH_FILTER_EN to add a 3-sample agreement filter on each synced line.
module shift_reg_input #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          i_ds,
  input  logic                          i_sh_clk,
  input  logic                          i_latch,
  output logic [WIDTH-1:0]              o_data,
  output logic                          o_valid,
  output logic                          o_frame_err,
  output logic [$clog2(WIDTH+2)-1:0]    o_bit_count
);

  localparam int unsigned CW = $clog2(WIDTH+2);
`ifdef SHIFT_REG_INPUT_GLITCH_FILTER_EN
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 3;
`else
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int unsigned AW = $clog2(ARM_CYCLES+1);

  // Line vector layout: bit 0 = data, bit 1 = shift clock, bit 2 = latch.
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       line_s;
  logic [2:0]       line_l;
  logic [2:1]       prev_q;
  logic [2:1]       rise;
  logic [AW-1:0]    arm_cnt;
  logic             armed;
  logic             shift_ev;
  logic             lat_ev;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {i_latch, i_sh_clk, i_ds};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign line_s = sync_q[SYNC_STAGES-1];

`ifdef SHIFT_REG_INPUT_GLITCH_FILTER_EN
  logic [2:0] hist0_q;
  logic [2:0] hist1_q;
  logic [2:0] filt_q;
  logic [2:0] agree;

  // Filtered level is combinational from the held level so the filter adds two cycles, not three.
  always_comb begin
    agree  = ~(line_s ^ hist0_q) & ~(line_s ^ hist1_q);
    line_l = (agree & line_s) | (~agree & filt_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist0_q <= '0;
      hist1_q <= '0;
      filt_q  <= '0;
    end else begin
      hist0_q <= line_s;
      hist1_q <= hist0_q;
      filt_q  <= line_l;
    end
  end
`else
  always_comb line_l = line_s;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      arm_cnt <= '0;
      prev_q  <= '0;
    end else begin
      prev_q <= line_l[2:1];
      if (!armed) arm_cnt <= arm_cnt + AW'(1);
    end
  end

  // Previous-value flops follow the lines while disarmed, so a line high through reset never edges.
  assign armed    = (arm_cnt == AW'(ARM_CYCLES));
  assign rise     = line_l[2:1] & ~prev_q & {2{armed}};
  assign shift_ev = rise[1];
  assign lat_ev   = rise[2];

  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = o_bit_count;
    if (shift_ev) begin
      if (MSB_FIRST != 0) shreg_nxt = {shreg[WIDTH-2:0], line_l[0]};
      else                shreg_nxt = {line_l[0], shreg[WIDTH-1:1]};
      if (o_bit_count != CW'(WIDTH+1)) cnt_nxt = o_bit_count + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_bit_count <= '0;
    end else begin
      shreg       <= shreg_nxt;
      o_valid     <= lat_ev;
      o_frame_err <= lat_ev && (cnt_nxt != CW'(WIDTH));
      if (lat_ev) begin
        o_data      <= shreg_nxt;
        o_bit_count <= '0;
      end else begin
        o_bit_count <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_input.sv
// Scoreboard bench for shift_reg_input: MSB-first and LSB-first instances share the same pins.
`timescale 1ns/1ps
module tb_shift_reg_input;

`ifdef SHIFT_REG_INPUT_GLITCH_FILTER_EN
  localparam int unsigned PH  = 6;
  localparam int unsigned LAT = 5;
  localparam int          GLITCH_BIT = 4;
`else
  localparam int unsigned PH  = 4;
  localparam int unsigned LAT = 3;
  localparam int          GLITCH_BIT = -1;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ds, sh, lat;
  logic [7:0] data_m, data_l;
  logic       v_m, v_l, e_m, e_l;
  logic [3:0] cnt_m, cnt_l;

  int unsigned cyc   = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned vseen = 0;
  int unsigned vmark;

  typedef struct {
    logic [7:0]  data;
    logic        err;
    int unsigned cyc;
  } exp_t;
  exp_t q_m[$];
  exp_t q_l[$];
  exp_t xm, xl;
  logic pv_m = 1'b0;
  logic pv_l = 1'b0;

  shift_reg_input #(.WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .i_ds(ds), .i_sh_clk(sh), .i_latch(lat),
    .o_data(data_m), .o_valid(v_m), .o_frame_err(e_m), .o_bit_count(cnt_m)
  );

  shift_reg_input #(.WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(0)) dut_lsb (
    .CLK(CLK), .RST_N(RST_N), .i_ds(ds), .i_sh_clk(sh), .i_latch(lat),
    .o_data(data_l), .o_valid(v_l), .o_frame_err(e_l), .o_bit_count(cnt_l)
  );

  always #31.25 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (v_m) begin
      vseen++;
      chk("msb valid single cycle", 32'(pv_m), 32'(0));
      chk("msb valid expected", 32'(q_m.size() != 0), 32'(1));
      if (q_m.size() != 0) begin
        xm = q_m.pop_front();
        chk("msb data", 32'(data_m), 32'(xm.data));
        chk("msb frame_err", 32'(e_m), 32'(xm.err));
        chk("msb latency", cyc - xm.cyc, LAT);
      end
    end
    if (v_l) begin
      vseen++;
      chk("lsb valid single cycle", 32'(pv_l), 32'(0));
      chk("lsb valid expected", 32'(q_l.size() != 0), 32'(1));
      if (q_l.size() != 0) begin
        xl = q_l.pop_front();
        chk("lsb data", 32'(data_l), 32'(xl.data));
        chk("lsb frame_err", 32'(e_l), 32'(xl.err));
        chk("lsb latency", cyc - xl.cyc, LAT);
      end
    end
    pv_m = v_m;
    pv_l = v_l;
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  // Data set at the start of the low phase; optional 1-cycle sh_clk glitch inside a stretched low phase.
  task automatic send_bit(input logic b, input logic glitch);
    ds = b;
    sh = 1'b0;
    if (glitch) begin
      cycles(2);
      sh = 1'b1;
      cycles(1);
      sh = 1'b0;
    end
    cycles(PH);
    sh = 1'b1;
    cycles(PH);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input int glitch_at);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], i == glitch_at);
  endtask

  task automatic do_latch(input logic [7:0] em, input logic [7:0] el, input logic err);
    sh = 1'b0;
    cycles(PH);
    lat = 1'b1;
    q_m.push_back('{em, err, cyc});
    q_l.push_back('{el, err, cyc});
    cycles(PH);
    lat = 1'b0;
    cycles(PH);
  endtask

  initial begin
    RST_N = 1'b0; ds = 1'b0; sh = 1'b0; lat = 1'b0;
    cycles(3);
    chk("reset data", 32'(data_m), 32'(0));
    chk("reset valid", 32'(v_m), 32'(0));
    chk("reset frame_err", 32'(e_m), 32'(0));
    chk("reset count", 32'(cnt_m), 32'(0));
    RST_N = 1'b1;
    cycles(8);

    // Full frame 1,0,1,1,0,0,0,1
    send_bits(16'h00B1, 8, -1);
    chk("count full msb", 32'(cnt_m), 32'(8));
    chk("count full lsb", 32'(cnt_l), 32'(8));
    do_latch(8'hB1, 8'h8D, 1'b0);
    chk("count cleared", 32'(cnt_m), 32'(0));

    // Ten bits: oldest two drop off, count saturates at 9
    send_bits(16'b1100000010, 10, -1);
    chk("count saturated msb", 32'(cnt_m), 32'(9));
    chk("count saturated lsb", 32'(cnt_l), 32'(9));
    do_latch(8'h02, 8'h40, 1'b1);

    // Short frame on top of previous contents, then re-latch without shifts
    send_bits(16'b10111, 5, -1);
    chk("count short", 32'(cnt_m), 32'(5));
    do_latch(8'h57, 8'hEA, 1'b1);
    chk("count after short latch", 32'(cnt_m), 32'(0));
    do_latch(8'h57, 8'hEA, 1'b1);

    // Lines held high through reset release
    sh = 1'b1; lat = 1'b1;
    RST_N = 1'b0;
    cycles(3);
    chk("mid reset data", 32'(data_m), 32'(0));
    vmark = vseen;
    RST_N = 1'b1;
    cycles(20);
    chk("held high no valid", vseen, vmark);
    chk("held high count", 32'(cnt_m), 32'(0));
    sh = 1'b0; lat = 1'b0;
    cycles(10);
    chk("falling edges count", 32'(cnt_m), 32'(0));
    chk("falling edges no valid", vseen, vmark);

    // Reset after four bits, then a clean 0x5A frame
    send_bits(16'h000F, 4, -1);
    chk("partial count", 32'(cnt_m), 32'(4));
    RST_N = 1'b0;
    cycles(3);
    chk("partial discarded", 32'(cnt_m), 32'(0));
    RST_N = 1'b1;
    cycles(10);
    chk("no valid on reset exit", vseen, vmark);
    send_bits(16'h005A, 8, GLITCH_BIT);
    chk("count 5A", 32'(cnt_m), 32'(8));
    do_latch(8'h5A, 8'h5A, 1'b0);

    for (int i = 0; i < 50 && (q_m.size() != 0 || q_l.size() != 0); i++) @(negedge CLK);
    chk("scoreboard drained", 32'(q_m.size() + q_l.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_input.md
Name: shift_reg_input

Overview:
- Receive-side counterpart of the three-wire 74HC595-style shift-register link: serial data, shift clock and latch.
- Oversamples the three lines on the system clock and shifts data bits in on shift-clock rising edges.
- Transfers the assembled word to a parallel output on latch rising edges.
- Used as an in-fabric model or loopback checker for the seven-segment driver link, and as a receiver from a peer FPGA pin header.

Parameters:
- WIDTH, 8: bits per frame and the width of o_data.
- SYNC_STAGES, 2: synchroniser flops per input line; minimum 2.
- MSB_FIRST, 1: 1 means the first bit received lands in o_data[WIDTH-1]. 0 means the first bit lands in o_data[0].

Ports:
- CLK  input  1  system clock, 16 MHz.
- RST_N  input  1  asynchronous active-low reset.
- i_ds  input  1  serial data line, asynchronous to CLK.
- i_sh_clk  input  1  shift clock line, asynchronous to CLK.
- i_latch  input  1  latch line, asynchronous to CLK.
- o_data  output  WIDTH  last latched word.
- o_valid  output  1  one-CLK pulse when o_data updates.
- o_frame_err  output  1  one-CLK pulse, coincident with o_valid, when the bit count at latch is not WIDTH.
- o_bit_count  output  $clog2(WIDTH+2)  bits shifted since the last latch; saturates at WIDTH+1.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Sync flops, edge-detect flops, shift register, o_data and o_bit_count go to 0.
  - o_valid and o_frame_err go to 0.
  - The arm counter clears.
- Arming:
  - After RST_N rises, the arm counter runs for SYNC_STAGES+1 CLK cycles.
  - Edge detectors track line levels during this window but report no edges.
  - A line held high through reset therefore produces no spurious shift or latch.
- Synchronisation:
  - Each line passes through SYNC_STAGES flops, giving ds_s, clk_s and lat_s.
  - Each synced line also has a previous-value flop.
- Shift event (clk_s=1 and previous clk_s=0):
  - Sample ds_s in that same cycle.
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], ds_s}.
  - MSB_FIRST=0: shreg <= {ds_s, shreg[WIDTH-1:1]}.
  - o_bit_count increments, saturating at WIDTH+1.
- Latch event (lat_s rising):
  - o_data <= shreg and o_valid=1 for exactly one cycle.
  - o_frame_err=1 in the same cycle if the count is not WIDTH, counting a same-cycle shift.
  - o_bit_count returns to 0.
  - shreg is NOT cleared: a re-latch with no new shifts re-presents the old word and flags a frame error (count 0).
- Shift and latch in the same cycle: the shift applies first. The latched word includes the new bit, and the count used for the error check includes it.
- Extra bits (more than WIDTH shifts): the oldest bits fall off the far end. o_data holds the last WIDTH bits received; the frame error is flagged.
- Falling edges of any line: no action.
- Latency: pin latch rise to o_valid is SYNC_STAGES+1 CLK cycles, ±1 for metastability resolution.
- Sender timing requirements:
  - sh_clk and latch high and low times ≥ SYNC_STAGES+1 CLK cycles.
  - ds stable ≥ 2 CLK cycles before and after each sh_clk rising edge.
  - Violations: behaviour undefined but no lockup.
- Reset mid-frame: partial frame discarded; no o_valid pulse on exit from reset.

Optional Feature:
- Macro: SHIFT_REG_INPUT_GLITCH_FILTER_EN.
- Defined:
  - Each synced line passes a 3-sample majority-agreement filter. The filtered level changes only when the last 3 samples agree.
  - Pulses shorter than 3 CLK cycles are rejected.
  - Latency increases by 2 cycles (latch to o_valid = SYNC_STAGES+3).
  - Minimum high/low times increase to SYNC_STAGES+3 cycles.
  - The arm window extends to SYNC_STAGES+3.
- Undefined: no filter; behaviour as above.

Test Plan:
- Reset, then shift 8 bits 1,0,1,1,0,0,0,1 with 4-cycle clk phases, then latch (WIDTH=8, MSB_FIRST=1).
  - Expect o_data=8'hB1 and a single-cycle o_valid with o_frame_err=0.
  - o_valid arrives 3 cycles after the pin latch edge.
  - o_bit_count returns to 0 afterwards.
- Same bit sequence with MSB_FIRST=0 → o_data=8'h8D.
- Shift 10 bits 1,1,0,0,0,0,0,0,1,0, then latch.
  - Expect o_data=8'h02 and o_frame_err=1 with o_valid.
  - o_bit_count reads 9 (saturated at WIDTH+1) just before the latch.
- Shift 5 bits, then latch:
  - Expect o_frame_err=1.
  - o_data holds the previous shreg contents shifted by those 5 bits.
  - A second latch with no shifts gives the same o_data with o_frame_err=1.
- Hold i_sh_clk=1 and i_latch=1 through reset release → no shift and no o_valid; o_bit_count stays 0.
- Assert RST_N low after 4 of 8 bits, then release and send a full frame 0x5A → o_data=8'h5A with no error. With GLITCH_FILTER_EN, a 1-cycle sh_clk glitch mid-frame causes no extra shift.
